alu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 32-bit datapath's register-register ALU instructions. It steps through the fetch and execute T-states and drives the register, bus, memory and ALU control strobes. It also issues the one-hot ALU operation select and handshakes with memory during instruction read. It sits between the top-level CPU control (start/done) and the datapath (bus, Y/Z, HI/LO, MAR/MDR, IR, general-register select logic).

---
 rtl/alu_seq_pkg.sv | 59 +++++
 rtl/alu_sequencer_alu_op_decode.sv | 54 +++++
 rtl/alu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_seq_pkg : shared types and constants for the ALU control sequencer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int ALU_ADD    = 0;
  localparam int ALU_INCPC  = 1;
  localparam int ALU_AND    = 2;
  localparam int ALU_OR     = 3;
  localparam int ALU_BRANCH = 4;
  localparam int ALU_NEGATE = 5;
  localparam int ALU_NOT    = 6;
  localparam int ALU_SUB    = 7;
  localparam int ALU_MUL    = 8;
  localparam int ALU_DIV    = 9;
  localparam int ALU_SHR    = 10;
  localparam int ALU_SHRA   = 11;
  localparam int ALU_SHL    = 12;
  localparam int ALU_ROR    = 13;
  localparam int ALU_ROL    = 14;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_alu_op_decode.sv
// +--------------------------------------------------------------------------+
// | alu_op_decode : opcode to one-hot ALU select and operation class         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0]  opcode,
  output logic [14:0] alu_sel,
  output logic        is_unary,
  output logic        is_wide,
  output logic        legal
);

  always_comb begin
    alu_sel  = '0;
    is_unary = 1'b0;
    is_wide  = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_ADD:  alu_sel[ALU_ADD]  = 1'b1;
      OP_SUB:  alu_sel[ALU_SUB]  = 1'b1;
      OP_AND:  alu_sel[ALU_AND]  = 1'b1;
      OP_OR:   alu_sel[ALU_OR]   = 1'b1;
      OP_SHR:  alu_sel[ALU_SHR]  = 1'b1;
      OP_SHRA: alu_sel[ALU_SHRA] = 1'b1;
      OP_SHL:  alu_sel[ALU_SHL]  = 1'b1;
      OP_ROR:  alu_sel[ALU_ROR]  = 1'b1;
      OP_ROL:  alu_sel[ALU_ROL]  = 1'b1;
      OP_MUL: begin
        alu_sel[ALU_MUL] = 1'b1;
        is_wide          = 1'b1;
      end
      OP_DIV: begin
        alu_sel[ALU_DIV] = 1'b1;
        is_wide          = 1'b1;
      end
      OP_NEG: begin
        alu_sel[ALU_NEGATE] = 1'b1;
        is_unary            = 1'b1;
      end
      OP_NOT: begin
        alu_sel[ALU_NOT] = 1'b1;
        is_unary         = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +--------------------------------------------------------------------------+
// | alu_sequencer : multi-cycle T-state controller for R-type ALU ops        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [4:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic        pc_out,
  output logic        mar_in,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        lo_in,
  output logic        hi_in,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic [14:0] alu_sel
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT) < 4) ? 4 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_err;

  logic [14:0] w_dec_sel;
  logic        w_is_unary;
  logic        w_is_wide;
  logic        w_legal;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .alu_sel  (w_dec_sel),
    .is_unary (w_is_unary),
    .is_wide  (w_is_wide),
    .legal    (w_legal)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_err      <= ERR_NONE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_T0;
          r_err   <= ERR_NONE;
        end
        S_T0: begin
          r_wait_cnt <= '0;
          r_state    <= S_T1;
        end
        S_T1: begin
          if (mem_ready) begin
            r_state <= S_T2;
          end else if (r_wait_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            r_err   <= ERR_TIMEOUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_T2: r_state <= S_T3;
        S_T3: begin
          if (w_legal) begin
            r_state <= S_T4;
          end else begin
            r_state <= S_DONE;
            r_err   <= ERR_ILLEGAL;
          end
        end
        S_T4: r_state <= S_T5;
        S_T5: r_state <= w_is_wide ? S_T6 : S_DONE;
        S_T6: r_state <= S_DONE;
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from the state register; the opcode only becomes valid
  // once IR is loaded, so T3-T6 strobes cannot be precomputed a cycle early.
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    err_code = (r_state == S_DONE) ? r_err : ERR_NONE;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlo_out  = 1'b0;
    zhi_out  = 1'b0;
    lo_in    = 1'b0;
    hi_in    = 1'b0;
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    r_in     = 1'b0;
    r_out    = 1'b0;
    alu_sel  = '0;
    case (r_state)
      S_T0: begin
        pc_out             = 1'b1;
        mar_in             = 1'b1;
        z_in               = 1'b1;
        alu_sel[ALU_INCPC] = 1'b1;
      end
      S_T1: begin
        zlo_out = 1'b1;
        pc_in   = 1'b1;
        read    = 1'b1;
        mdr_in  = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: if (w_legal) begin
        grb   = 1'b1;
        r_out = 1'b1;
        y_in  = 1'b1;
      end
      S_T4: begin
        alu_sel = w_dec_sel;
        z_in    = 1'b1;
        grc     = !w_is_unary;
        r_out   = !w_is_unary;
      end
      S_T5: begin
        zlo_out = 1'b1;
        lo_in   = w_is_wide;
        gra     = !w_is_wide;
        r_in    = !w_is_wide;
      end
      S_T6: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_alu_sequencer : directed self-checking bench for alu_sequencer        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [4:0]  opcode;
  logic        busy, done;
  logic [1:0]  err_code;
  logic        pc_out, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in;
  logic        zlo_out, zhi_out, lo_in, hi_in, gra, grb, grc, r_in, r_out;
  logic [14:0] alu_sel;
  logic [17:0] strobes;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] M_PC_OUT  = 18'h20000;
  localparam logic [17:0] M_MAR_IN  = 18'h10000;
  localparam logic [17:0] M_PC_IN   = 18'h08000;
  localparam logic [17:0] M_READ    = 18'h04000;
  localparam logic [17:0] M_MDR_IN  = 18'h02000;
  localparam logic [17:0] M_MDR_OUT = 18'h01000;
  localparam logic [17:0] M_IR_IN   = 18'h00800;
  localparam logic [17:0] M_Y_IN    = 18'h00400;
  localparam logic [17:0] M_Z_IN    = 18'h00200;
  localparam logic [17:0] M_ZLO_OUT = 18'h00100;
  localparam logic [17:0] M_ZHI_OUT = 18'h00080;
  localparam logic [17:0] M_LO_IN   = 18'h00040;
  localparam logic [17:0] M_HI_IN   = 18'h00020;
  localparam logic [17:0] M_GRA     = 18'h00010;
  localparam logic [17:0] M_GRB     = 18'h00008;
  localparam logic [17:0] M_GRC     = 18'h00004;
  localparam logic [17:0] M_R_IN    = 18'h00002;
  localparam logic [17:0] M_R_OUT   = 18'h00001;

  localparam logic [17:0] S_T0 = M_PC_OUT | M_MAR_IN | M_Z_IN;
  localparam logic [17:0] S_T1 = M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN;
  localparam logic [17:0] S_T2 = M_MDR_OUT | M_IR_IN;
  localparam logic [17:0] S_T3 = M_GRB | M_R_OUT | M_Y_IN;
  localparam logic [17:0] S_T4B = M_GRC | M_R_OUT | M_Z_IN;
  localparam logic [17:0] S_T5N = M_ZLO_OUT | M_GRA | M_R_IN;
  localparam logic [17:0] S_T5W = M_ZLO_OUT | M_LO_IN;
  localparam logic [17:0] S_T6 = M_ZHI_OUT | M_HI_IN;

  assign strobes = {pc_out, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in,
                    zlo_out, zhi_out, lo_in, hi_in, gra, grb, grc, r_in, r_out};

  alu_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .busy      (busy),
    .done      (done),
    .err_code  (err_code),
    .pc_out    (pc_out),
    .mar_in    (mar_in),
    .pc_in     (pc_in),
    .read      (read),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .ir_in     (ir_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .zlo_out   (zlo_out),
    .zhi_out   (zhi_out),
    .lo_in     (lo_in),
    .hi_in     (hi_in),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .r_in      (r_in),
    .r_out     (r_out),
    .alu_sel   (alu_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic b, input logic d, input logic [1:0] e,
                       input logic [14:0] a, input logic [17:0] s);
    logic [36:0] obs;
    logic [36:0] exp;
    obs = {busy, done, err_code, alu_sel, strobes};
    exp = {b, d, e, a, s};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Leaves the bench at the negedge of the T0 cycle.
  task automatic launch(input logic [4:0] op);
    @(negedge clock);
    opcode = op;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic fetch_ok(input string tag);
    check({tag, "_t0"}, 1, 0, 2'b00, 15'h0002, S_T0); step();
    check({tag, "_t1"}, 1, 0, 2'b00, 15'h0000, S_T1); step();
    check({tag, "_t2"}, 1, 0, 2'b00, 15'h0000, S_T2); step();
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; mem_ready = 1'b1; opcode = 5'b00000;
    repeat (2) @(negedge clock);
    check("reset", 0, 0, 2'b00, 15'h0000, 18'h0);
    clear = 1'b0;

    // ADD, mem_ready high: done lands 7 cycles after the start edge
    launch(5'b00011);
    fetch_ok("add");
    check("add_t3", 1, 0, 2'b00, 15'h0000, S_T3);  step();
    check("add_t4", 1, 0, 2'b00, 15'h0001, S_T4B); step();
    check("add_t5", 1, 0, 2'b00, 15'h0000, S_T5N); step();
    check("add_done", 1, 1, 2'b00, 15'h0000, 18'h0); step();
    check("add_idle", 0, 0, 2'b00, 15'h0000, 18'h0);

    // MUL: wide result path through T6, no r_in
    launch(5'b01111);
    fetch_ok("mul");
    check("mul_t3", 1, 0, 2'b00, 15'h0000, S_T3);  step();
    check("mul_t4", 1, 0, 2'b00, 15'h0100, S_T4B); step();
    check("mul_t5", 1, 0, 2'b00, 15'h0000, S_T5W); step();
    check("mul_t6", 1, 0, 2'b00, 15'h0000, S_T6);  step();
    check("mul_done", 1, 1, 2'b00, 15'h0000, 18'h0);
    // start raised during DONE must not skip the IDLE cycle
    opcode = 5'b10001;
    start  = 1'b1;
    step();
    check("b2b_idle", 0, 0, 2'b00, 15'h0000, 18'h0);
    step();
    start = 1'b0;

    // NEG: unary, T4 has no register read
    fetch_ok("neg");
    check("neg_t3", 1, 0, 2'b00, 15'h0000, S_T3);   step();
    check("neg_t4", 1, 0, 2'b00, 15'h0020, M_Z_IN); step();
    check("neg_t5", 1, 0, 2'b00, 15'h0000, S_T5N);  step();
    check("neg_done", 1, 1, 2'b00, 15'h0000, 18'h0); step();

    // ADD with three wait cycles in T1
    mem_ready = 1'b0;
    launch(5'b00011);
    check("wait_t0", 1, 0, 2'b00, 15'h0002, S_T0); step();
    check("wait_t1a", 1, 0, 2'b00, 15'h0000, S_T1); step();
    check("wait_t1b", 1, 0, 2'b00, 15'h0000, S_T1); step();
    check("wait_t1c", 1, 0, 2'b00, 15'h0000, S_T1); step();
    mem_ready = 1'b1;
    check("wait_t1d", 1, 0, 2'b00, 15'h0000, S_T1); step();
    check("wait_t2", 1, 0, 2'b00, 15'h0000, S_T2);  step();
    check("wait_t3", 1, 0, 2'b00, 15'h0000, S_T3);  step();
    check("wait_t4", 1, 0, 2'b00, 15'h0001, S_T4B); step();
    check("wait_t5", 1, 0, 2'b00, 15'h0000, S_T5N); step();
    check("wait_done", 1, 1, 2'b00, 15'h0000, 18'h0); step();

    // Memory never ready: 15 T1 cycles then timeout
    mem_ready = 1'b0;
    launch(5'b00011);
    check("to_t0", 1, 0, 2'b00, 15'h0002, S_T0); step();
    for (int i = 0; i < 15; i++) begin
      check("to_t1", 1, 0, 2'b00, 15'h0000, S_T1); step();
    end
    check("to_done", 1, 1, 2'b10, 15'h0000, 18'h0); step();
    check("to_idle", 0, 0, 2'b00, 15'h0000, 18'h0);
    mem_ready = 1'b1;

    // Illegal opcode: T3 silent, error code 01
    launch(5'b11111);
    fetch_ok("ill");
    check("ill_t3", 1, 0, 2'b00, 15'h0000, 18'h0); step();
    check("ill_done", 1, 1, 2'b01, 15'h0000, 18'h0); step();

    // Clear in T4 of DIV aborts the instruction
    launch(5'b10000);
    fetch_ok("div");
    check("div_t3", 1, 0, 2'b00, 15'h0000, S_T3);
    step();
    check("div_t4", 1, 0, 2'b00, 15'h0200, S_T4B);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_idle", 0, 0, 2'b00, 15'h0000, 18'h0);

    launch(5'b00011);
    fetch_ok("add2");
    check("add2_t3", 1, 0, 2'b00, 15'h0000, S_T3);  step();
    check("add2_t4", 1, 0, 2'b00, 15'h0001, S_T4B); step();
    check("add2_t5", 1, 0, 2'b00, 15'h0000, S_T5N); step();
    check("add2_done", 1, 1, 2'b00, 15'h0000, 18'h0); step();
    check("add2_idle", 0, 0, 2'b00, 15'h0000, 18'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
